// File: rtl/enemy_grid_ctrl.sv
// Enemy slot lifetimes, spawn/hit/expiry resolution and
// sprite-relative pixel coordinates for the hole grid.
module enemy_grid_ctrl #(
  parameter int SLOTS        = 3,
  parameter int ROWS         = 3,
  parameter int COLS         = 3,
  parameter int SPR_W        = 160,
  parameter int SPR_H        = 120,
  parameter int X0           = 40,
  parameter int Y0           = 50,
  parameter int PITCH_X      = 170,
  parameter int PITCH_Y      = 130,
  parameter int ROW_SHIFT    = 20,
  parameter int LIFE         = 90,
  parameter int FLASH_FRAMES = 8,
  localparam int HOLES = ROWS * COLS,
  localparam int HW    = ($clog2(HOLES) < 1) ? 1 : $clog2(HOLES),
  localparam int MW    = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic [9:0]       h_cnt,
  input  logic [9:0]       v_cnt,
  input  logic             spawn_valid,
  input  logic [HW-1:0]    spawn_hole,
  output logic             spawn_ready,
  input  logic             key_valid,
  input  logic [HW-1:0]    key_hole,
  output logic [9:0]       H,
  output logic [9:0]       V,
  output logic             pix_valid,
  output logic             pix_flash,
  output logic             hit_pulse,
  output logic [MW-1:0]    miss_num,
  output logic [HOLES-1:0] active_mask
);

  localparam int CMAX = (LIFE > FLASH_FRAMES) ? LIFE : FLASH_FRAMES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [HW:0]   HOLES_W = (HW + 1)'(HOLES);
  localparam logic [CW-1:0] C_LIFE  = CW'(LIFE);
  localparam logic [CW-1:0] C_FLASH = CW'(FLASH_FRAMES);
  localparam logic [CW-1:0] C_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_FREE,
    S_UP,
    S_FLASH
  } slot_e;

  slot_e         r_st   [SLOTS];
  slot_e         w_st_n [SLOTS];
  logic [HW-1:0] r_hole [SLOTS];
  logic [HW-1:0] w_hole_n [SLOTS];
  logic [CW-1:0] r_cnt  [SLOTS];
  logic [CW-1:0] w_cnt_n [SLOTS];

  logic [SLOTS-1:0] w_free;
  logic [SLOTS-1:0] w_key;
  logic             w_sp_occ;
  logic             w_hole_ok;
  logic             w_accept;
  logic             w_taken;
  logic             w_hit;
  logic [MW-1:0]    w_miss;
  logic [HOLES-1:0] w_occ;
  logic [HOLES-1:0] w_hflash;
  logic [HOLES-1:0] w_mask_n;

  logic [HOLES-1:0] w_in;
  logic [9:0]       w_offh [HOLES];
  logic [9:0]       w_offv [HOLES];
  logic [9:0]       w_h;
  logic [9:0]       w_v;
  logic             w_pv;
  logic             w_pf;

  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             r_pv;
  logic             r_pf;
  logic             r_hit;
  logic [MW-1:0]    r_miss;
  logic [HOLES-1:0] r_mask;

  always_comb begin
    w_free   = '0;
    w_key    = '0;
    w_sp_occ = 1'b0;
    w_occ    = '0;
    w_hflash = '0;
    for (int s = 0; s < SLOTS; s++) begin
      w_free[s] = (r_st[s] == S_FREE);
      w_key[s]  = key_valid && (r_st[s] == S_UP)
                  && (r_hole[s] == key_hole);
      if (r_st[s] != S_FREE) begin
        if (r_hole[s] == spawn_hole) w_sp_occ = 1'b1;
        w_occ[r_hole[s]] = 1'b1;
        if (r_st[s] == S_FLASH) w_hflash[r_hole[s]] = 1'b1;
      end
    end
  end

  assign w_hole_ok   = {1'b0, spawn_hole} < HOLES_W;
  assign spawn_ready = (|w_free) && w_hole_ok && !w_sp_occ;
  assign w_accept    = spawn_valid && spawn_ready;

  // A hit takes priority over an expiry landing on the same cycle.
  always_comb begin
    w_taken = 1'b0;
    w_hit   = 1'b0;
    w_miss  = '0;
    for (int s = 0; s < SLOTS; s++) begin
      w_st_n[s]   = r_st[s];
      w_hole_n[s] = r_hole[s];
      w_cnt_n[s]  = r_cnt[s];
      unique case (r_st[s])
        S_FREE: begin
          if (w_accept && !w_taken) begin
            w_taken     = 1'b1;
            w_st_n[s]   = S_UP;
            w_hole_n[s] = spawn_hole;
            w_cnt_n[s]  = C_LIFE;
          end
        end
        S_UP: begin
          if (w_key[s]) begin
            w_hit      = 1'b1;
            w_st_n[s]  = S_FLASH;
            w_cnt_n[s] = C_FLASH;
          end else if (frame_tick) begin
            if (r_cnt[s] == C_ONE) begin
              w_st_n[s]  = S_FREE;
              w_cnt_n[s] = '0;
              w_miss     = w_miss + 1'b1;
            end else begin
              w_cnt_n[s] = r_cnt[s] - 1'b1;
            end
          end
        end
        S_FLASH: begin
          if (frame_tick) begin
            if (r_cnt[s] == C_ONE) begin
              w_st_n[s]  = S_FREE;
              w_cnt_n[s] = '0;
            end else begin
              w_cnt_n[s] = r_cnt[s] - 1'b1;
            end
          end
        end
        default: begin
          w_st_n[s]  = S_FREE;
          w_cnt_n[s] = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_mask_n = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (w_st_n[s] != S_FREE) w_mask_n[w_hole_n[s]] = 1'b1;
    end
  end

  for (genvar g = 0; g < HOLES; g++) begin : g_box
    localparam int XL = X0 + (g / COLS) * ROW_SHIFT + (g % COLS) * PITCH_X;
    localparam int YT = Y0 + (g / COLS) * PITCH_Y;
    logic signed [31:0] w_dx;
    logic signed [31:0] w_dy;
    assign w_dx = $signed({22'd0, h_cnt}) - XL;
    assign w_dy = $signed({22'd0, v_cnt}) - YT;
    assign w_in[g] = (w_dx > 0) && (w_dx < SPR_W)
                     && (w_dy > 0) && (w_dy < SPR_H);
    assign w_offh[g] = w_dx[9:0];
    assign w_offv[g] = w_dy[9:0];
  end

  // Descending scan so the lowest occupied hole index wins on overlap.
  always_comb begin
    w_h  = '0;
    w_v  = '0;
    w_pv = 1'b0;
    w_pf = 1'b0;
    for (int i = HOLES - 1; i >= 0; i--) begin
      if (w_in[i] && w_occ[i]) begin
        w_h  = w_offh[i];
        w_v  = w_offv[i];
        w_pv = 1'b1;
        w_pf = w_hflash[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SLOTS; s++) begin
        r_st[s]   <= S_FREE;
        r_hole[s] <= '0;
        r_cnt[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < SLOTS; s++) begin
        r_st[s]   <= w_st_n[s];
        r_hole[s] <= w_hole_n[s];
        r_cnt[s]  <= w_cnt_n[s];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h    <= '0;
      r_v    <= '0;
      r_pv   <= 1'b0;
      r_pf   <= 1'b0;
      r_hit  <= 1'b0;
      r_miss <= '0;
      r_mask <= '0;
    end else begin
      r_h    <= w_h;
      r_v    <= w_v;
      r_pv   <= w_pv;
      r_pf   <= w_pf;
      r_hit  <= w_hit;
      r_miss <= w_miss;
      r_mask <= w_mask_n;
    end
  end

  assign H           = r_h;
  assign V           = r_v;
  assign pix_valid   = r_pv;
  assign pix_flash   = r_pf;
  assign hit_pulse   = r_hit;
  assign miss_num    = r_miss;
  assign active_mask = r_mask;

endmodule

// File: tb/tb_enemy_grid_ctrl.sv
// Scoreboard bench for enemy_grid_ctrl: a per-hole reference
// model predicts registered outputs, a monitor compares them.
module tb_enemy_grid_ctrl;

  localparam int SLOTS = 3;
  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int HOLES = ROWS * COLS;
  localparam int HW = 4;
  localparam int MW = 2;
  localparam int SPR_W = 160;
  localparam int SPR_H = 120;
  localparam int X0 = 40;
  localparam int Y0 = 50;
  localparam int PITCH_X = 170;
  localparam int PITCH_Y = 130;
  localparam int ROW_SHIFT = 20;
  localparam int LIFE = 90;
  localparam int FLASH_FRAMES = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_tick = 1'b0;
  logic [9:0]       h_cnt = '0;
  logic [9:0]       v_cnt = '0;
  logic             spawn_valid = 1'b0;
  logic [HW-1:0]    spawn_hole = '0;
  logic             spawn_ready;
  logic             key_valid = 1'b0;
  logic [HW-1:0]    key_hole = '0;
  logic [9:0]       H;
  logic [9:0]       V;
  logic             pix_valid;
  logic             pix_flash;
  logic             hit_pulse;
  logic [MW-1:0]    miss_num;
  logic [HOLES-1:0] active_mask;

  enemy_grid_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .spawn_valid (spawn_valid),
    .spawn_hole  (spawn_hole),
    .spawn_ready (spawn_ready),
    .key_valid   (key_valid),
    .key_hole    (key_hole),
    .H           (H),
    .V           (V),
    .pix_valid   (pix_valid),
    .pix_flash   (pix_flash),
    .hit_pulse   (hit_pulse),
    .miss_num    (miss_num),
    .active_mask (active_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int v;
    int pv;
    int pf;
    int hit;
    int miss;
    int mask;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   running = 1'b0;

  // mode: 0 empty, 1 enemy up, 2 flashing
  int mode [HOLES];
  int left [HOLES];

  function automatic void chk(string n, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, expv, $time);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < HOLES; i++) begin
      mode[i] = 0;
      left[i] = 0;
    end
  endfunction

  function automatic int model_ready(int sh);
    int live = 0;
    for (int i = 0; i < HOLES; i++) if (mode[i] != 0) live++;
    return (live < SLOTS && sh < HOLES && mode[sh % 16 < HOLES ? sh : 0] == 0
            && sh < HOLES) ? 1 : 0;
  endfunction

  function automatic exp_t model_step(bit sv, int sh, bit kv, int kh,
                                      bit tk, int hc, int vc, int rdy);
    exp_t e;
    bit found = 1'b0;
    e = '{0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < HOLES; i++) begin
      int xl = X0 + (i / COLS) * ROW_SHIFT + (i % COLS) * PITCH_X;
      int yt = Y0 + (i / COLS) * PITCH_Y;
      if (!found && mode[i] != 0 && hc > xl && hc < xl + SPR_W
          && vc > yt && vc < yt + SPR_H) begin
        found = 1'b1;
        e.h = hc - xl;
        e.v = vc - yt;
        e.pv = 1;
        e.pf = (mode[i] == 2) ? 1 : 0;
      end
    end
    for (int i = 0; i < HOLES; i++) begin
      if (mode[i] == 1 && kv && kh == i) begin
        mode[i] = 2;
        left[i] = FLASH_FRAMES;
        e.hit = 1;
      end else if (mode[i] != 0 && tk) begin
        left[i]--;
        if (left[i] == 0) begin
          if (mode[i] == 1) e.miss++;
          mode[i] = 0;
        end
      end
    end
    if (sv && rdy == 1) begin
      mode[sh] = 1;
      left[sh] = LIFE;
    end
    for (int i = 0; i < HOLES; i++) if (mode[i] != 0) e.mask |= (1 << i);
    return e;
  endfunction

  task automatic step(input bit sv, input int sh, input bit kv,
                      input int kh, input bit tk, input int hc,
                      input int vc);
    int   rdy;
    exp_t e;
    @(negedge clk);
    rst_n       = 1'b1;
    spawn_valid = sv;
    spawn_hole  = HW'(sh);
    key_valid   = kv;
    key_hole    = HW'(kh);
    frame_tick  = tk;
    h_cnt       = 10'(hc);
    v_cnt       = 10'(vc);
    #1;
    rdy = model_ready(sh);
    chk("spawn_ready", int'(spawn_ready), rdy);
    e = model_step(sv, sh, kv, kh, tk, hc, vc, rdy);
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit tk);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, tk, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    spawn_valid = 1'b0;
    key_valid   = 1'b0;
    frame_tick  = 1'b0;
    #1;
    chk("rst_H", int'(H), 0);
    chk("rst_V", int'(V), 0);
    chk("rst_pix_valid", int'(pix_valid), 0);
    chk("rst_pix_flash", int'(pix_flash), 0);
    chk("rst_hit", int'(hit_pulse), 0);
    chk("rst_miss", int'(miss_num), 0);
    chk("rst_mask", int'(active_mask), 0);
    model_clear();
    q.delete();
    repeat (2) @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && running) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: got no expected entry at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("H", int'(H), e.h);
          chk("V", int'(V), e.v);
          chk("pix_valid", int'(pix_valid), e.pv);
          chk("pix_flash", int'(pix_flash), e.pf);
          chk("hit_pulse", int'(hit_pulse), e.hit);
          chk("miss_num", int'(miss_num), e.miss);
          chk("active_mask", int'(active_mask), e.mask);
        end
      end
    end
  end

  initial begin : driver
    model_clear();
    do_reset();
    running = 1'b1;

    // hole 0 pixel window, edges outside the strict box
    step(1, 0, 0, 0, 0, 41, 51);
    step(0, 0, 0, 0, 0, 41, 51);
    step(0, 0, 0, 0, 0, 40, 51);
    step(0, 0, 0, 0, 0, 200, 51);
    step(0, 0, 0, 0, 0, 199, 169);
    step(0, 0, 0, 0, 0, 0, 0);

    // hole 3: free first, then occupied
    step(0, 0, 0, 0, 0, 61, 181);
    step(1, 3, 0, 0, 0, 61, 181);
    step(0, 0, 0, 0, 0, 61, 181);
    step(0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // capacity, duplicate and out-of-range spawn
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0, 0, 0);
    step(1, 12, 0, 0, 0, 0, 0);
    do_reset();
    step(1, 9, 0, 0, 0, 0, 0);
    step(1, 15, 0, 0, 0, 0, 0);

    // hole 4 times out after LIFE ticks
    step(1, 4, 0, 0, 0, 0, 0);
    idle(LIFE, 1);
    idle(2, 0);

    // hole 2 hit, flash, second key ignored, spawn on flash hole refused
    step(1, 2, 0, 0, 0, 0, 0);
    step(0, 0, 1, 2, 0, 0, 0);
    step(0, 0, 1, 2, 0, 381, 51);
    step(1, 2, 0, 0, 1, 381, 51);
    idle(FLASH_FRAMES, 1);
    idle(2, 0);

    // spawn and key same hole same cycle, key out of range
    step(1, 6, 1, 6, 0, 0, 0);
    step(0, 0, 1, 13, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    do_reset();

    // key on the final life tick wins
    step(1, 5, 0, 0, 0, 0, 0);
    idle(LIFE - 1, 1);
    step(0, 0, 1, 5, 1, 0, 0);
    idle(2, 0);

    // reset mid-flash
    step(0, 0, 1, 5, 0, 231, 181);
    do_reset();

    // randomized play
    for (int n = 0; n < 2500; n++) begin
      if ($urandom % 700 == 0) do_reset();
      step(($urandom % 3) == 0, int'($urandom % 16),
           ($urandom % 3) == 0, int'($urandom % 16),
           ($urandom % 2) == 0, int'($urandom % 640),
           int'($urandom % 480));
    end

    @(posedge clk);
    #2;
    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enemy_grid_ctrl.md
Name: enemy_grid_ctrl

Overview:
Owns enemy (mole) lifetime and on-screen placement for a ROWS x COLS hole grid with up to SLOTS simultaneous enemies. Accepts spawn requests from the game sequencer, ages enemies per frame, and resolves player key hits into HIT/flash or timeout MISS. Drives sprite-relative pixel coordinates H/V one cycle after h_cnt/v_cnt for the sprite ROM address generator, plus per-pixel valid/flash flags for the pixel mux.

Parameters:
SLOTS, 3, max concurrent enemies (>=1)
ROWS, 3, grid rows
COLS, 3, grid columns
SPR_W, 160, sprite width in pixels
SPR_H, 120, sprite height in pixels
X0, 40, left edge of hole (0,0)
Y0, 50, top edge of hole (0,0)
PITCH_X, 170, horizontal hole pitch
PITCH_Y, 130, vertical hole pitch
ROW_SHIFT, 20, extra x offset per row (stagger)
LIFE, 90, frames an un-hit enemy stays up
FLASH_FRAMES, 8, frames a hit enemy shows the flash sprite
Derived: HOLES=ROWS*COLS; HW=max(1,clog2(HOLES)); hole index = row*COLS+col.

Ports:
clk  in  1  system clock
rst_n  in  1  reset
frame_tick  in  1  one-cycle pulse per video frame
h_cnt  in  10  VGA horizontal pixel counter
v_cnt  in  10  VGA vertical pixel counter
spawn_valid  in  1  spawn request
spawn_hole  in  HW  requested hole index
spawn_ready  out  1  spawn accepted this cycle when high with spawn_valid
key_valid  in  1  one-cycle player key press
key_hole  in  HW  hole index of pressed key
H  out  10  sprite-relative x
V  out  10  sprite-relative y
pix_valid  out  1  current pixel lies on a live enemy sprite
pix_flash  out  1  that enemy is in hit-flash
hit_pulse  out  1  one-cycle hit strobe
miss_num  out  clog2(SLOTS+1)  enemies expired this cycle
active_mask  out  HOLES  bit per hole occupied (UP or FLASH)

Behaviour:
- Reset is asynchronous, active-low: clk with rst_n; all slots FREE, all counters 0, H=V=0, pix_valid=pix_flash=0, hit_pulse=0, miss_num=0, active_mask=0. Reset mid-game clears everything immediately; no pulses emitted.
- Per-slot FSM FREE -> UP -> (FLASH ->) FREE; each slot holds hole index and frame counter, width clog2(max(LIFE,FLASH_FRAMES)+1).
- spawn_ready (combinational) = some slot FREE AND spawn_hole < HOLES AND spawn_hole not occupied. Accept on spawn_valid&&spawn_ready: lowest-index FREE slot -> UP, counter=LIFE, visible next cycle.
- UP: counter decrements on frame_tick; tick with counter==1 -> FREE, counts into miss_num that cycle.
- key_valid with key_hole matching an UP slot -> FLASH, counter=FLASH_FRAMES, hit_pulse=1 next cycle (registered). Key on FREE, FLASH or out-of-range hole: ignored, no pulse.
- FLASH: decrements on frame_tick; tick with counter==1 -> FREE, no miss.
- Same cycle hit and expiry on a slot: hit wins, no miss. Spawn and key on same hole same cycle: key ignored (enemy not yet up). Spawn into a FLASH hole: spawn_ready=0.
- miss_num: registered, count of slots expiring that cycle (0..SLOTS).
- Pixel path, 1-cycle latency: hole (r,c) box xl=X0+r*ROW_SHIFT+c*PITCH_X, yt=Y0+r*PITCH_Y; inside iff xl<h_cnt<xl+SPR_W and yt<v_cnt<yt+SPR_H (strict). If inside an occupied hole: H=h_cnt-xl, V=v_cnt-yt, pix_valid=1, pix_flash=(FLASH). Otherwise H=V=0, pix_valid=pix_flash=0. Overlapping boxes: lowest hole index wins. State used is that of the same cycle h_cnt is sampled.
- active_mask registered, reflects slot state after the current edge.

Test Plan:
- Reset, spawn hole 0, h_cnt=41,v_cnt=51 -> next cycle H=1,V=1,pix_valid=1,pix_flash=0; h_cnt=40 or 200 -> pix_valid=0,H=V=0.
- Spawn hole 3 (row1,col0), h_cnt=61,v_cnt=181 -> H=1,V=1; with hole 3 free -> pix_valid=0.
- Spawn holes 0,1,2 -> spawn_ready=0 for hole 4 (SLOTS=3); respawn hole 1 while occupied -> spawn_ready=0.
- Spawn hole 4, 90 frame_ticks, no key -> miss_num=1 for one cycle after 90th tick, active_mask[4]=0.
- Spawn hole 2, key_hole=2 -> hit_pulse one cycle, pix_flash=1 in box; after 8 ticks FREE, miss_num stays 0; second key in FLASH -> no pulse.
- key_valid on same cycle as final life tick -> hit_pulse=1, miss_num=0; rst_n low mid-flash -> active_mask=0, outputs 0 immediately.
